m_ucode_loader: RTL and testbench

M_UCODE_LOADER -- requirements
Module: m_ucode_loader

---
 rtl/m_ucode_loader.sv | 128 ++++++++++++
 tb/tb_m_ucode_loader.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/m_ucode_loader.sv
// Microcode loader: packs a byte stream into 48-bit control-store words,
// strobes each word into the store, then verifies a trailing checksum byte.
module m_ucode_loader #(
  parameter int unsigned NWORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic [7:0]  waddr,
  output logic [47:0] wdata,
  output logic        we,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int unsigned IDXW = 9;
  localparam int unsigned CNTW = 10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    WRITE   = 3'd2,
    CHECK   = 3'd3,
    FIN     = 3'd4
  } state_t;

  state_t            state;
  logic [IDXW-1:0]   widx;
  logic [2:0]        bcnt;
  logic [7:0]        csum;
  logic [39:0]       word;
  logic              xfer;

  assign xfer = byte_valid & byte_ready;

  // Partial bytes live in word so wdata only changes on entry to WRITE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      widx       <= '0;
      bcnt       <= '0;
      csum       <= '0;
      word       <= '0;
      byte_ready <= 1'b0;
      waddr      <= '0;
      wdata      <= '0;
      we         <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      we <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            done       <= 1'b0;
            err        <= 1'b0;
            widx       <= '0;
            bcnt       <= '0;
            csum       <= '0;
            byte_ready <= 1'b1;
            busy       <= 1'b1;
            state      <= COLLECT;
          end
        end
        COLLECT: begin
          if (xfer) begin
            csum <= csum + byte_data;
            case (bcnt)
              3'd0:    word[7:0]   <= byte_data;
              3'd1:    word[15:8]  <= byte_data;
              3'd2:    word[23:16] <= byte_data;
              3'd3:    word[31:24] <= byte_data;
              3'd4:    word[39:32] <= byte_data;
              default: ;
            endcase
            if (bcnt == 3'd5) begin
              bcnt       <= '0;
              wdata      <= {byte_data, word};
              waddr      <= widx[7:0];
              we         <= 1'b1;
              byte_ready <= 1'b0;
              state      <= WRITE;
            end else begin
              bcnt <= bcnt + 3'd1;
            end
          end
        end
        WRITE: begin
          widx       <= widx + IDXW'(1);
          byte_ready <= 1'b1;
          // Compare in a wider domain so NWORDS=256 never aliases to zero.
          if ((CNTW'(widx) + CNTW'(1)) < CNTW'(NWORDS)) begin
            state <= COLLECT;
          end else begin
            state <= CHECK;
          end
        end
        CHECK: begin
          if (xfer) begin
            csum       <= csum + byte_data;
            byte_ready <= 1'b0;
            state      <= FIN;
          end
        end
        FIN: begin
          if (csum == 8'h00) begin
            done <= 1'b1;
          end else begin
            err <= 1'b1;
          end
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          byte_ready <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_m_ucode_loader.sv
// Directed bench for m_ucode_loader: a 2-word instance for protocol cases
// and a 256-word instance for the full-store load.
module tb_m_ucode_loader;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b, start, byte_valid;
  logic [7:0]  byte_data;

  logic        ready_a, we_a, busy_a, done_a, err_a;
  logic [7:0]  waddr_a;
  logic [47:0] wdata_a;
  logic        ready_b, we_b, busy_b, done_b, err_b;
  logic [7:0]  waddr_b;
  logic [47:0] wdata_b;

  m_ucode_loader #(.NWORDS(2)) u_dut_a (
    .clk(clk), .rst(rst_a), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(ready_a), .waddr(waddr_a),
    .wdata(wdata_a), .we(we_a), .busy(busy_a), .done(done_a), .err(err_a)
  );

  m_ucode_loader #(.NWORDS(256)) u_dut_b (
    .clk(clk), .rst(rst_b), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(ready_b), .waddr(waddr_b),
    .wdata(wdata_b), .we(we_b), .busy(busy_b), .done(done_b), .err(err_b)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Sampled view of whichever instance is selected
  bit          sel_b = 1'b0;
  logic        s_ready, s_we, s_busy, s_done, s_err;
  logic [7:0]  s_waddr;
  logic [47:0] s_wdata;

  logic [7:0]  stream [0:1599];
  int          slen, sidx, cnt;
  bit          offered, toggle;
  logic [7:0]  wa_q [$];
  logic [47:0] wd_q [$];

  // Advance to the next falling edge, sample outputs, then present the next byte.
  task automatic step();
    @(negedge clk);
    cnt++;
    s_ready = sel_b ? ready_b : ready_a;
    s_we    = sel_b ? we_b    : we_a;
    s_busy  = sel_b ? busy_b  : busy_a;
    s_done  = sel_b ? done_b  : done_a;
    s_err   = sel_b ? err_b   : err_a;
    s_waddr = sel_b ? waddr_b : waddr_a;
    s_wdata = sel_b ? wdata_b : wdata_a;
    if (offered) sidx++;
    if (s_we) begin
      wa_q.push_back(s_waddr);
      wd_q.push_back(s_wdata);
    end
    byte_valid = (sidx < slen) && (!toggle || (cnt % 2 == 1));
    byte_data  = (sidx < slen) ? stream[sidx] : 8'h00;
    offered    = byte_valid && s_ready;
  endtask

  task automatic fill_seq(input logic [7:0] ck);
    for (int i = 0; i < 12; i++) stream[i] = 8'(i + 1);
    stream[12] = ck;
    slen = 13;
  endtask

  task automatic run_load(input string tag, input int max_cyc, input int start_at, output int cyc);
    sidx = 0;
    wa_q.delete();
    wd_q.delete();
    start = 1'b1;
    cnt = 0;
    step();
    start = 1'b0;
    check({tag, "_busy"}, 64'(s_busy), 64'd1);
    check({tag, "_flags_clr"}, 64'({s_done, s_err}), 64'd0);
    while (!(s_done || s_err) && cnt < max_cyc) begin
      step();
      start = (cnt == start_at);
    end
    start = 1'b0;
    cyc = cnt;
    if (cnt >= max_cyc) check({tag, "_timeout"}, 64'(cnt), 64'(max_cyc - 1));
  endtask

  task automatic check_two_words(input string tag);
    check({tag, "_nwr"}, 64'(wa_q.size()), 64'd2);
    if (wa_q.size() == 2) begin
      check({tag, "_a0"}, 64'(wa_q[0]), 64'd0);
      check({tag, "_d0"}, 64'(wd_q[0]), 64'h060504030201);
      check({tag, "_a1"}, 64'(wa_q[1]), 64'd1);
      check({tag, "_d1"}, 64'(wd_q[1]), 64'h0C0B0A090807);
    end
  endtask

  int cyc;

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; start = 1'b0;
    byte_valid = 1'b0; byte_data = 8'h00;
    slen = 0; sidx = 0; cnt = 0; offered = 1'b0; toggle = 1'b0;
    repeat (3) step();
    rst_a = 1'b0;
    step();
    check("rst_ready", 64'(s_ready), 64'd0);
    check("rst_busy",  64'(s_busy),  64'd0);
    check("rst_we",    64'(s_we),    64'd0);
    check("rst_flags", 64'({s_done, s_err}), 64'd0);
    check("rst_waddr", 64'(s_waddr), 64'd0);
    check("rst_wdata", 64'(s_wdata), 64'd0);

    // Good checksum: 0x4E + 0xB2 wraps to zero; done 7*2+3 cycles after start
    fill_seq(8'hB2);
    run_load("good", 100, -1, cyc);
    check_two_words("good");
    check("good_done", 64'({s_done, s_err}), 64'b10);
    check("good_cyc", 64'(cyc), 64'd17);
    repeat (3) step();
    check("good_sticky", 64'({s_done, s_err, s_busy}), 64'b100);

    // Bad checksum
    fill_seq(8'hB3);
    run_load("bad", 100, -1, cyc);
    check_two_words("bad");
    check("bad_flags", 64'({s_done, s_err}), 64'b01);

    // byte_valid on alternate cycles doubles the byte-transfer time
    fill_seq(8'hB2);
    toggle = 1'b1;
    run_load("tog", 200, -1, cyc);
    toggle = 1'b0;
    check_two_words("tog");
    check("tog_done", 64'({s_done, s_err}), 64'b10);
    check("tog_cyc", 64'(cyc), 64'd27);

    // Reset after the 3rd byte of the first word: no write must leak out
    fill_seq(8'hB2);
    sidx = 0; wa_q.delete(); wd_q.delete();
    start = 1'b1; cnt = 0;
    step();
    start = 1'b0;
    while (sidx < 3 && cnt < 50) step();
    rst_a = 1'b1; offered = 1'b0; byte_valid = 1'b0;
    step();
    rst_a = 1'b0; offered = 1'b0; byte_valid = 1'b0;
    repeat (4) step();
    check("abort_nwr", 64'(wa_q.size()), 64'd0);
    check("abort_state", 64'({s_busy, s_ready, s_done, s_err}), 64'd0);
    run_load("reload", 100, -1, cyc);
    check_two_words("reload");
    check("reload_done", 64'({s_done, s_err}), 64'b10);

    // start pulsed mid-load is ignored
    fill_seq(8'hB2);
    run_load("midstart", 100, 9, cyc);
    check_two_words("midstart");
    check("midstart_done", 64'({s_done, s_err}), 64'b10);
    check("midstart_cyc", 64'(cyc), 64'd17);

    // Full 256-word store: all 0xFF with checksum 0x00
    rst_a = 1'b1; rst_b = 1'b0; sel_b = 1'b1;
    repeat (2) step();
    for (int i = 0; i < 1536; i++) stream[i] = 8'hFF;
    stream[1536] = 8'h00;
    slen = 1537;
    run_load("full", 3000, -1, cyc);
    check("full_nwr", 64'(wa_q.size()), 64'd256);
    for (int i = 0; i < wa_q.size(); i++) begin
      check($sformatf("full_a%0d", i), 64'(wa_q[i]), 64'(i));
      check($sformatf("full_d%0d", i), 64'(wd_q[i]), 64'hFFFFFFFFFFFF);
    end
    check("full_done", 64'({s_done, s_err}), 64'b10);
    check("full_cyc", 64'(cyc), 64'd1795);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
